// File: rtl/swd_target.sv
// Target-side SWD-DP serial engine: oversamples the host's swclk/swdio on clk,
// decodes request headers, answers with ACK and read data, and receives write
// data, handing decoded transactions to an upstream register model.
module swd_target #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LRST_BITS   = 50,
    parameter int unsigned STATETRACE  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        swclk,
    input  logic        swdi,
    output logic        swdo,
    output logic        swwr,
    output logic        apndp,
    output logic        rnw,
    output logic [1:0]  addr32,
    output logic        req,
    input  logic [2:0]  ack,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        wr,
    output logic        err,
    output logic        lrst
);

    localparam int unsigned    LW       = $clog2(LRST_BITS + 1);
    localparam logic [LW-1:0] LRST_MAX = LW'(LRST_BITS);
    localparam logic [LW-1:0] LRST_PRE = LW'(LRST_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TRN1,
        S_ACK,
        S_RDATA,
        S_TRN2,
        S_TRN2W,
        S_WDATA
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] swclk_sync_q, swclk_sync_d;
    logic [SYNC_STAGES-1:0] swdi_sync_q, swdi_sync_d;
    logic                   swclk_prev_q, swclk_prev_d;
    logic [5:0]             bit_cnt_q, bit_cnt_d;
    logic [32:0]            shift_q, shift_d;
    logic [32:0]            rdata_q, rdata_d;
    logic [2:0]             ack_q, ack_d;
    logic [LW-1:0]          lcnt_q, lcnt_d;
    logic                   swdo_q, swdo_d;
    logic                   swwr_q, swwr_d;
    logic                   apndp_q, apndp_d;
    logic                   rnw_q, rnw_d;
    logic [1:0]             addr32_q, addr32_d;
    logic                   req_q, req_d;
    logic [31:0]            dout_q, dout_d;
    logic                   wr_q, wr_d;
    logic                   err_q, err_d;
    logic                   lrst_q, lrst_d;

    logic                   swclk_s;
    logic                   swdi_s;
    logic                   sw_edge;
    logic [6:0]             hdr;
    logic                   hdr_ok;

    assign swclk_s = swclk_sync_q[SYNC_STAGES-1];
    assign swdi_s  = swdi_sync_q[SYNC_STAGES-1];
    assign sw_edge = swclk_s & ~swclk_prev_q;

    // Next-state, datapath and output decode; all protocol work happens on a detected swclk rising edge.
    always_comb begin
        state_d      = state_q;
        swclk_sync_d = {swclk_sync_q[SYNC_STAGES-2:0], swclk};
        swdi_sync_d  = {swdi_sync_q[SYNC_STAGES-2:0], swdi};
        swclk_prev_d = swclk_s;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rdata_d      = rdata_q;
        ack_d        = ack_q;
        lcnt_d       = lcnt_q;
        swdo_d       = swdo_q;
        swwr_d       = swwr_q;
        apndp_d      = apndp_q;
        rnw_d        = rnw_q;
        addr32_d     = addr32_q;
        dout_d       = dout_q;
        req_d        = 1'b0;
        wr_d         = 1'b0;
        err_d        = 1'b0;
        lrst_d       = 1'b0;
        hdr          = shift_d[32:26];
        hdr_ok       = 1'b0;

        if (sw_edge) begin
            if (!swdi_s) begin
                lcnt_d = '0;
            end else if (!swwr_q && (lcnt_q != LRST_MAX)) begin
                lcnt_d = lcnt_q + 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    // Only a 1 that follows a 0 can be a start bit.
                    if (swdi_s && (lcnt_q == '0)) begin
                        bit_cnt_d = '0;
                        state_d   = S_HDR;
                    end
                end
                S_HDR: begin
                    shift_d   = {swdi_s, shift_q[32:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    hdr       = shift_d[32:26];
                    hdr_ok    = ((^hdr[3:0]) == hdr[4]) && !hdr[5] && hdr[6];
                    if (bit_cnt_q == 6'd6) begin
                        if (hdr_ok) begin
                            apndp_d  = hdr[0];
                            rnw_d    = hdr[1];
                            addr32_d = {hdr[3], hdr[2]};
                            req_d    = 1'b1;
                            state_d  = S_TRN1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_TRN1: begin
                    ack_d     = ack;
                    rdata_d   = {^din, din};
                    swwr_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = S_ACK;
                end
                S_ACK: begin
                    swdo_d    = ack_q[bit_cnt_q[1:0]];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 6'd2) begin
                        bit_cnt_d = '0;
                        if (ack_q == 3'b001) begin
                            state_d = rnw_q ? S_RDATA : S_TRN2W;
                        end else begin
                            state_d = S_TRN2;
                        end
                    end
                end
                S_RDATA: begin
                    swdo_d    = rdata_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 6'd32) begin
                        state_d = S_TRN2;
                    end
                end
                S_TRN2: begin
                    swwr_d  = 1'b0;
                    state_d = S_IDLE;
                end
                S_TRN2W: begin
                    swwr_d    = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_WDATA;
                end
                S_WDATA: begin
                    shift_d   = {swdi_s, shift_q[32:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 6'd32) begin
                        if ((^shift_d[31:0]) == shift_d[32]) begin
                            dout_d = shift_d[31:0];
                            wr_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Line reset pre-empts whatever the current phase would have produced.
            if (swdi_s && !swwr_q && (lcnt_q == LRST_PRE)) begin
                lrst_d  = 1'b1;
                swwr_d  = 1'b0;
                req_d   = 1'b0;
                wr_d    = 1'b0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            swclk_sync_q <= '0;
            swdi_sync_q  <= '0;
            swclk_prev_q <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rdata_q      <= '0;
            ack_q        <= '0;
            lcnt_q       <= '0;
            swdo_q       <= 1'b0;
            swwr_q       <= 1'b0;
            apndp_q      <= 1'b0;
            rnw_q        <= 1'b0;
            addr32_q     <= '0;
            req_q        <= 1'b0;
            dout_q       <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            lrst_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            swclk_sync_q <= swclk_sync_d;
            swdi_sync_q  <= swdi_sync_d;
            swclk_prev_q <= swclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            lcnt_q       <= lcnt_d;
            swdo_q       <= swdo_d;
            swwr_q       <= swwr_d;
            apndp_q      <= apndp_d;
            rnw_q        <= rnw_d;
            addr32_q     <= addr32_d;
            req_q        <= req_d;
            dout_q       <= dout_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            lrst_q       <= lrst_d;
        end
    end

    // State tracing is a simulation-only aid; the synthesizable view carries no trace logic.
    if (STATETRACE != 0) begin : g_trace
    end

    assign swdo   = swdo_q;
    assign swwr   = swwr_q;
    assign apndp  = apndp_q;
    assign rnw    = rnw_q;
    assign addr32 = addr32_q;
    assign req    = req_q;
    assign dout   = dout_q;
    assign wr     = wr_q;
    assign err    = err_q;
    assign lrst   = lrst_q;

endmodule

// File: tb/tb_swd_target.sv
// Bench for swd_target: a host model bit-bangs swclk/swdio in loopback with
// the target and compares the responses with expectations derived from the
// SWD protocol rules.
module tb_swd_target;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        swclk  = 1'b0;
    logic        host_o = 1'b0;
    logic        swdi;
    logic        swdo, swwr, apndp, rnw, req, wr, err, lrst;
    logic [1:0]  addr32;
    logic [2:0]  ack_in = 3'b001;
    logic [31:0] din_in = '0;
    logic [31:0] dout;

    int vectors     = 0;
    int miscompares = 0;
    int req_cnt = 0, wr_cnt = 0, err_cnt = 0, lrst_cnt = 0;
    logic        cap_apndp = 1'b0, cap_rnw = 1'b0;
    logic [1:0]  cap_addr = '0;
    logic        req_p = 1'b0, wr_p = 1'b0, err_p = 1'b0, lrst_p = 1'b0;
    logic [31:0] model_dout = '0;

    always #5 clk = ~clk;

    // Shared DIO line: whoever owns the turnaround drives it.
    assign swdi = swwr ? swdo : host_o;

    swd_target #(.SYNC_STAGES(2), .LRST_BITS(50), .STATETRACE(0)) dut (
        .clk(clk), .rst(rst), .swclk(swclk), .swdi(swdi), .swdo(swdo), .swwr(swwr),
        .apndp(apndp), .rnw(rnw), .addr32(addr32), .req(req), .ack(ack_in), .din(din_in),
        .dout(dout), .wr(wr), .err(err), .lrst(lrst)
    );

    // Pulse monitor: counts strobes, captures decoded fields, checks pulse shape.
    always @(negedge clk) begin
        if (rst) begin
            if (req) begin
                req_cnt++;
                cap_apndp = apndp;
                cap_rnw   = rnw;
                cap_addr  = addr32;
            end
            if (wr)   wr_cnt++;
            if (err)  err_cnt++;
            if (lrst) lrst_cnt++;
            if (req | wr | err | lrst) begin
                vectors++;
                if ((req & req_p) | (wr & wr_p) | (err & err_p) | (lrst & lrst_p) | (req & err)) begin
                    miscompares++;
                    $display("FAIL pulse_shape: req=%b/%b wr=%b/%b err=%b/%b lrst=%b/%b, required single-clk pulses and no req with err",
                             req_p, req, wr_p, wr, err_p, err, lrst_p, lrst);
                end
            end
        end
        req_p  = req;
        wr_p   = wr;
        err_p  = err;
        lrst_p = lrst;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic par32(input logic [31:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    function automatic logic [7:0] mk_hdr(input logic ap, input logic rn, input logic [1:0] a);
        logic p;
        p = ($countones({a, rn, ap}) % 2) == 1;
        return {1'b1, 1'b0, p, a[1], a[0], rn, ap, 1'b1};
    endfunction

    // One SWD bit period: data set up in the low phase, target output read late in the high phase.
    task automatic bit_cycle(input logic h, output logic t_o, output logic t_wr);
        host_o = h;
        repeat (8) @(posedge clk);
        #1 swclk = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        t_o  = swdo;
        t_wr = swwr;
        swclk = 1'b0;
    endtask

    task automatic idle_bits(input int n, input logic v);
        logic t, w;
        for (int i = 0; i < n; i++) bit_cycle(v, t, w);
    endtask

    // Host-side transaction; the host knows the register model's ack, so it follows the expected path.
    task automatic host_xfer(input logic [7:0] hb, input logic valid, input logic rn,
                             input logic [2:0] ack_v, input logic [31:0] din_v,
                             input logic [31:0] wd, input logic wpar,
                             output logic [2:0] o_ack, output logic [32:0] o_rd,
                             output logic o_wr_hdr, output logic o_drv, output logic o_wr_end);
        logic t, w;
        ack_in = ack_v;
        din_in = din_v;
        req_cnt = 0; wr_cnt = 0; err_cnt = 0; lrst_cnt = 0;
        o_ack = '0; o_rd = '0; o_wr_hdr = 1'b0; o_drv = 1'b0; o_wr_end = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(hb[i], t, w);
            o_wr_hdr |= w;
        end
        if (valid) begin
            bit_cycle(1'b0, t, o_drv);
            for (int k = 0; k < 3; k++) begin
                bit_cycle(1'b0, t, w);
                o_ack[k] = t;
            end
            if (ack_v == 3'b001 && rn) begin
                for (int k = 0; k < 33; k++) begin
                    bit_cycle(1'b0, t, w);
                    o_rd[k] = t;
                end
                bit_cycle(1'b0, t, o_wr_end);
            end else if (ack_v == 3'b001) begin
                bit_cycle(1'b0, t, o_wr_end);
                for (int k = 0; k < 32; k++) bit_cycle(wd[k], t, w);
                bit_cycle(wpar, t, w);
            end else begin
                bit_cycle(1'b0, t, o_wr_end);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit_cycle(1'b0, t, w);
                o_wr_hdr |= w;
            end
        end
        idle_bits(2, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({swdo, swwr, apndp, rnw, addr32, req, wr, err, lrst} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, required 0", {swdo, swwr, apndp, rnw, addr32, req, wr, err, lrst});
        end
        vectors++;
        if (dout !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_dout: got %h, required 00000000", dout);
        end
        rst = 1'b1;
        repeat (4) @(posedge clk);
        model_dout = '0;
    endtask

    task automatic test_read_ap();
        logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        host_xfer(8'hAF, 1'b1, 1'b1, 3'b001, 32'habcdef12, '0, 1'b0, a, d, wh, dv, we);
        vectors++;
        if (req_cnt !== 1) begin miscompares++; $display("FAIL rd_req_count: got %0d, required 1", req_cnt); end
        vectors++;
        if ({cap_apndp, cap_rnw, cap_addr} !== 4'b1101) begin
            miscompares++; $display("FAIL rd_decode: got %b, required 1101", {cap_apndp, cap_rnw, cap_addr});
        end
        vectors++;
        if (a !== 3'b001) begin miscompares++; $display("FAIL rd_ack: got %b, required 001", a); end
        vectors++;
        if (d !== {1'b1, 32'habcdef12}) begin miscompares++; $display("FAIL rd_data: got %h, required 1abcdef12", d); end
        vectors++;
        if ({wh, dv, we} !== 3'b010) begin
            miscompares++; $display("FAIL rd_swwr: hdr/trn1/end got %b, required 010", {wh, dv, we});
        end
        vectors++;
        if (err_cnt !== 0) begin miscompares++; $display("FAIL rd_err: got %0d, required 0", err_cnt); end
    endtask

    task automatic test_write_dp();
        logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        host_xfer(mk_hdr(1'b0, 1'b0, 2'b10), 1'b1, 1'b0, 3'b001, '0, 32'h12345678, 1'b1, a, d, wh, dv, we);
        model_dout = 32'h12345678;
        vectors++;
        if ({cap_apndp, cap_rnw, cap_addr} !== 4'b0010) begin
            miscompares++; $display("FAIL wr_decode: got %b, required 0010", {cap_apndp, cap_rnw, cap_addr});
        end
        vectors++;
        if ({wr_cnt, err_cnt} !== {32'd1, 32'd0}) begin
            miscompares++; $display("FAIL wr_pulses: wr=%0d err=%0d, required wr=1 err=0", wr_cnt, err_cnt);
        end
        vectors++;
        if (dout !== model_dout) begin miscompares++; $display("FAIL wr_dout: got %h, required %h", dout, model_dout); end
        vectors++;
        if (we !== 1'b0) begin miscompares++; $display("FAIL wr_trn2w: swwr got %b, required 0", we); end
    endtask

    task automatic test_write_bad_parity();
        logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        host_xfer(mk_hdr(1'b0, 1'b0, 2'b10), 1'b1, 1'b0, 3'b001, '0, 32'h12345678, 1'b0, a, d, wh, dv, we);
        vectors++;
        if ({wr_cnt, err_cnt} !== {32'd0, 32'd1}) begin
            miscompares++; $display("FAIL wpar_pulses: wr=%0d err=%0d, required wr=0 err=1", wr_cnt, err_cnt);
        end
        vectors++;
        if (dout !== model_dout) begin miscompares++; $display("FAIL wpar_dout: got %h, required %h", dout, model_dout); end
    endtask

    task automatic test_bad_header();
        logic [7:0] hb; logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        hb = 8'hAF;
        hb[5] = ~hb[5];
        host_xfer(hb, 1'b0, 1'b1, 3'b001, 32'h5555aaaa, '0, 1'b0, a, d, wh, dv, we);
        vectors++;
        if ({req_cnt, err_cnt} !== {32'd0, 32'd1}) begin
            miscompares++; $display("FAIL hdr_pulses: req=%0d err=%0d, required req=0 err=1", req_cnt, err_cnt);
        end
        vectors++;
        if (wh !== 1'b0) begin miscompares++; $display("FAIL hdr_swwr: got %b, required 0", wh); end
    endtask

    task automatic test_wait();
        logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        host_xfer(8'hAF, 1'b1, 1'b1, 3'b010, 32'hdeadbeef, '0, 1'b0, a, d, wh, dv, we);
        vectors++;
        if (a !== 3'b010) begin miscompares++; $display("FAIL wait_ack: got %b, required 010", a); end
        vectors++;
        if (we !== 1'b0) begin miscompares++; $display("FAIL wait_trn2: swwr got %b, required 0", we); end
        vectors++;
        if ({req_cnt, wr_cnt, err_cnt} !== {32'd1, 32'd0, 32'd0}) begin
            miscompares++; $display("FAIL wait_pulses: req=%0d wr=%0d err=%0d, required 1 0 0", req_cnt, wr_cnt, err_cnt);
        end
    endtask

    task automatic test_line_reset();
        logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        host_xfer(8'hAF, 1'b1, 1'b1, 3'b001, 32'h0f0f0f0f, '0, 1'b0, a, d, wh, dv, we);
        req_cnt = 0; err_cnt = 0; lrst_cnt = 0;
        // First 1 after idle opens a header; seven more 1s break its stop bit.
        idle_bits(49, 1'b1);
        vectors++;
        if ({lrst_cnt, err_cnt, req_cnt} !== {32'd0, 32'd1, 32'd0}) begin
            miscompares++; $display("FAIL lrst_49: lrst=%0d err=%0d req=%0d, required 0 1 0", lrst_cnt, err_cnt, req_cnt);
        end
        idle_bits(1, 1'b1);
        vectors++;
        if (lrst_cnt !== 1) begin miscompares++; $display("FAIL lrst_50: got %0d, required 1", lrst_cnt); end
        vectors++;
        if (swwr !== 1'b0) begin miscompares++; $display("FAIL lrst_swwr: got %b, required 0", swwr); end
        idle_bits(10, 1'b1);
        vectors++;
        if (lrst_cnt !== 1) begin miscompares++; $display("FAIL lrst_sat: got %0d, required 1", lrst_cnt); end
        idle_bits(2, 1'b0);
        host_xfer(8'hAF, 1'b1, 1'b1, 3'b001, 32'h13572468, '0, 1'b0, a, d, wh, dv, we);
        vectors++;
        if ({req_cnt, a} !== {32'd1, 3'b001}) begin
            miscompares++; $display("FAIL lrst_after: req=%0d ack=%b, required 1 001", req_cnt, a);
        end
        vectors++;
        if (d !== {par32(32'h13572468), 32'h13572468}) begin
            miscompares++; $display("FAIL lrst_after_data: got %h, required %h", d, {par32(32'h13572468), 32'h13572468});
        end
    endtask

    task automatic test_reset_mid();
        logic t, w; logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        logic [7:0] hb;
        hb = 8'hAF;
        for (int i = 0; i < 4; i++) bit_cycle(hb[i], t, w);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({swwr, apndp, rnw, addr32, dout} !== '0) begin
            miscompares++; $display("FAIL midrst_state: got %h, required 0", {swwr, apndp, rnw, addr32, dout});
        end
        rst = 1'b1;
        model_dout = '0;
        repeat (3) @(posedge clk);
        host_xfer(mk_hdr(1'b0, 1'b1, 2'b11), 1'b1, 1'b1, 3'b001, 32'h89abcdef, '0, 1'b0, a, d, wh, dv, we);
        vectors++;
        if ({req_cnt, cap_apndp, cap_rnw, cap_addr} !== {32'd1, 4'b0111}) begin
            miscompares++; $display("FAIL midrst_req: req=%0d fields=%b, required 1 0111", req_cnt, {cap_apndp, cap_rnw, cap_addr});
        end
        vectors++;
        if (d !== {par32(32'h89abcdef), 32'h89abcdef}) begin
            miscompares++; $display("FAIL midrst_data: got %h, required %h", d, {par32(32'h89abcdef), 32'h89abcdef});
        end
    endtask

    task automatic test_random();
        logic ap, rn, valid, ok, wpar, exp_wr, exp_err;
        logic [1:0] ad; logic [2:0] ackv; logic [31:0] dv32, wd; logic [7:0] hb;
        int fault;
        logic [2:0] a; logic [32:0] d; logic wh, dv, we;
        for (int n = 0; n < 30; n++) begin
            ap = 1'($urandom_range(0, 1));
            rn = 1'($urandom_range(0, 1));
            ad = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    ackv = 3'b001;
                2:       ackv = 3'b010;
                default: ackv = 3'b100;
            endcase
            dv32  = $urandom;
            wd    = $urandom;
            fault = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            hb    = mk_hdr(ap, rn, ad);
            if (fault != 0) hb[fault + 4] = ~hb[fault + 4];
            wpar  = par32(wd) ^ ($urandom_range(0, 7) == 0);
            valid = (fault == 0);
            host_xfer(hb, valid, rn, ackv, dv32, wd, wpar, a, d, wh, dv, we);
            ok      = valid && (ackv == 3'b001);
            exp_wr  = ok && !rn && (wpar == par32(wd));
            exp_err = !valid || (ok && !rn && (wpar != par32(wd)));
            if (exp_wr) model_dout = wd;
            vectors++;
            if ({req_cnt, wr_cnt, err_cnt} !== {32'(valid), 32'(exp_wr), 32'(exp_err)}) begin
                miscompares++;
                $display("FAIL rnd%0d_pulses: req=%0d wr=%0d err=%0d, required %0d %0d %0d",
                         n, req_cnt, wr_cnt, err_cnt, valid, exp_wr, exp_err);
            end
            vectors++;
            if (dout !== model_dout) begin miscompares++; $display("FAIL rnd%0d_dout: got %h, required %h", n, dout, model_dout); end
            if (valid) begin
                vectors++;
                if ({cap_apndp, cap_rnw, cap_addr, a, we} !== {ap, rn, ad, ackv, 1'b0}) begin
                    miscompares++;
                    $display("FAIL rnd%0d_resp: fields/ack/swwr got %b, required %b",
                             n, {cap_apndp, cap_rnw, cap_addr, a, we}, {ap, rn, ad, ackv, 1'b0});
                end
            end else begin
                vectors++;
                if (wh !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_noresp: swwr got %b, required 0", n, wh); end
            end
            if (ok && rn) begin
                vectors++;
                if (d !== {par32(dv32), dv32}) begin
                    miscompares++; $display("FAIL rnd%0d_rdata: got %h, required %h", n, d, {par32(dv32), dv32});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_ap();
        test_write_dp();
        test_write_bad_parity();
        test_bad_header();
        test_wait();
        test_line_reset();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
